// File: rtl/d_ff.sv
// d_ff: WIDTH-bit register pipeline of STAGES flops with synchronous active-high reset to RST_VAL.
// Latency: exactly STAGES rising clk edges from d to Q; Q is driven straight from the last stage.
// Backpressure: none; when D_FF_CE_EN is defined, en=0 freezes every stage (rst still wins).
module d_ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      STAGES  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef D_FF_CE_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];
    logic             en_w;

`ifdef D_FF_CE_EN
    assign en_w = en;
`else
    assign en_w = 1'b1;
`endif

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < int'(STAGES); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset overrides the enable so a held pipeline can still be cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else if (en_w) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign Q = stage_q[STAGES-1];

endmodule

// File: tb/tb_d_ff.sv
// Bench for d_ff: four instances (default, 3-stage x8, RST_VAL=FF x8, 2-stage x8 with optional enable).
// Expected outputs come from a per-edge pipeline model queued at each rising edge and checked at the falling edge.
module tb_d_ff;

`ifdef D_FF_CE_EN
    localparam bit HAS_EN = 1'b1;
`else
    localparam bit HAS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst0, rst1, rst2, rst3, en3;
    logic       d0;
    logic [7:0] d1, d2, d3;
    logic       q0;
    logic [7:0] q1, q2, q3;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
    logic [7:0]  sb0[$], sb1[$], sb2[$], sb3[$];

    always #5 clk = ~clk;

    d_ff u_dut0 (.clk(clk), .rst(rst0), .d(d0), .Q(q0));

    d_ff #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00)) u_dut1 (.clk(clk), .rst(rst1), .d(d1), .Q(q1));

    d_ff #(.WIDTH(8), .STAGES(1), .RST_VAL(8'hFF)) u_dut2 (.clk(clk), .rst(rst2), .d(d2), .Q(q2));

`ifdef D_FF_CE_EN
    d_ff #(.WIDTH(8), .STAGES(2), .RST_VAL(8'h3C)) u_dut3 (.clk(clk), .rst(rst3), .en(en3), .d(d3), .Q(q3));
`else
    d_ff #(.WIDTH(8), .STAGES(2), .RST_VAL(8'h3C)) u_dut3 (.clk(clk), .rst(rst3), .d(d3), .Q(q3));
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic at(input int t);
        #(t - int'($time));
    endtask

    // Model pipeline: stage 0 in the low byte, one byte per stage.
    function automatic logic [63:0] step(input logic [63:0] p, input logic [7:0] din,
                                         input logic r, input logic e, input logic [7:0] rv);
        if (r)      return {8{rv}};
        else if (e) return {p[55:0], din};
        else        return p;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            p0 = step(p0, {7'b0, d0}, rst0, 1'b1, 8'h00);
            p1 = step(p1, d1, rst1, 1'b1, 8'h00);
            p2 = step(p2, d2, rst2, 1'b1, 8'hFF);
            p3 = step(p3, d3, rst3, HAS_EN ? en3 : 1'b1, 8'h3C);
            sb0.push_back(p0[7:0]);
            sb1.push_back(p1[23:16]);
            sb2.push_back(p2[7:0]);
            sb3.push_back(p3[15:8]);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sb0.size() != 0) chk("sb_q0", 64'({7'b0, q0}), 64'(sb0.pop_front()));
            else                 chk("sb_q0_depth", 64'(sb0.size()), 64'd1);
            if (sb1.size() != 0) chk("sb_q1", 64'(q1), 64'(sb1.pop_front()));
            else                 chk("sb_q1_depth", 64'(sb1.size()), 64'd1);
            if (sb2.size() != 0) chk("sb_q2", 64'(q2), 64'(sb2.pop_front()));
            else                 chk("sb_q2_depth", 64'(sb2.size()), 64'd1);
            if (sb3.size() != 0) chk("sb_q3", 64'(q3), 64'(sb3.pop_front()));
            else                 chk("sb_q3_depth", 64'(sb3.size()), 64'd1);
        end
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1; en3 = 1'b1;
        d0 = 1'b0; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;

        at(6);
        chk("rst_q0", 64'(q0), 64'd0);
        chk("rst_q1", 64'(q1), 64'h00);
        chk("rst_q2_ff", 64'(q2), 64'hFF);
        chk("rst_q3", 64'(q3), 64'h3C);
        at(7);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        d1 = 8'hA5; d2 = 8'h5A; d3 = 8'h11;
        at(11); d0 = 1'b1;
        at(12); chk("glitch_hi", 64'(q0), 64'd0);
        at(14); d0 = 1'b0; chk("glitch_lo", 64'(q0), 64'd0);
        at(16);
        chk("e15_q0", 64'(q0), 64'd0);
        chk("p3_e15", 64'(q1), 64'h00);
        chk("e15_q2", 64'(q2), 64'h5A);
        at(17); d1 = 8'h00;
        at(21); d0 = 1'b1;
        at(26);
        chk("e25_q0", 64'(q0), 64'd1);
        chk("p3_e25", 64'(q1), 64'h00);
        chk("e25_q3", 64'(q3), 64'h11);
        at(27); d3 = 8'h22;
        at(36);
        chk("e35_q0", 64'(q0), 64'd1);
        chk("p3_e35", 64'(q1), 64'hA5);
        at(38); en3 = 1'b0; d3 = 8'h77;
        at(46);
        chk("e45_q0", 64'(q0), 64'd1);
        chk("p3_e45", 64'(q1), 64'h00);
        at(56);
        chk("e55_q0", 64'(q0), 64'd1);
`ifdef D_FF_CE_EN
        chk("ce_hold", 64'(q3), 64'h11);
`endif
        at(58); rst3 = 1'b1;
        at(63); d0 = 1'b0;
        at(66);
        chk("e65_q0", 64'(q0), 64'd0);
        chk("ce_rst_wins", 64'(q3), 64'h3C);
        at(67); rst3 = 1'b0; en3 = 1'b1;
        at(76); chk("e75_q0", 64'(q0), 64'd0);
        at(84); d0 = 1'b1;
        at(86); chk("e85_q0", 64'(q0), 64'd1);
        at(92); rst0 = 1'b1;
        at(96); chk("rst_mid", 64'(q0), 64'd0);
        at(97); rst0 = 1'b0;
        at(101); rst0 = 1'b1;
        at(103); rst0 = 1'b0;
        at(104); chk("rst_between_edges", 64'(q0), 64'd0);
        at(106); chk("follow_after_rst", 64'(q0), 64'd1);

        repeat (40) begin
            @(posedge clk);
            #3;
            d0 = 1'($urandom);
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            d3 = 8'($urandom);
            en3  = ($urandom_range(0, 3) != 0);
            rst0 = ($urandom_range(0, 7) == 0);
            rst1 = ($urandom_range(0, 7) == 0);
            rst2 = ($urandom_range(0, 7) == 0);
            rst3 = ($urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        #3;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0; en3 = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/d_ff.md
D_FF -- requirements
Module: d_ff

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 1, data width in bits (legal range 1..64).
REQ-002 The block SHALL expose parameter STAGES, default 1, number of register stages from d to Q (legal range 1..8).
REQ-003 The block SHALL expose parameter RST_VAL, default 0, the WIDTH-bit value loaded into every stage on reset.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge only.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port d, input, WIDTH bits, the data input.
REQ-007 The block SHALL have port Q, output, WIDTH bits, the registered data output, driven directly from the last stage register.
REQ-008 When D_FF_CE_EN is defined, the block SHALL have port en, input, 1 bit, the clock enable (see Configuration).

Function
REQ-009 At each rising clk edge with rst=0 (and en=1 when present): stage[0] <= d, and stage[i] <= stage[i-1] for i=1..STAGES-1.
REQ-010 Q SHALL equal stage[STAGES-1]; with STAGES=1 it equals d sampled at the previous rising edge, so latency is exactly STAGES rising edges.
REQ-011 Q SHALL NOT change between rising edges; changes on d or rst between edges SHALL have no effect until the next rising edge.
REQ-012 There SHALL be no combinational path from d, rst or en to Q.
REQ-013 All WIDTH bits SHALL be registered independently with no arithmetic or bit-width conversion; d bit k appears on Q bit k.
REQ-014 Before the first rising edge with rst=1, the contents of all stages are unspecified; the block SHALL NOT rely on an initial value.

Reset
REQ-015 At a rising edge with rst=1, every stage, and therefore Q, SHALL be loaded with RST_VAL, overriding d and en.
REQ-016 Reset SHALL take effect on the edge where it is sampled high, not asynchronously; Q SHALL show RST_VAL after that edge.
REQ-017 Deasserting rst mid-operation SHALL cause stage[0] to capture d on the first edge with rst=0; the remaining stages SHALL keep shifting RST_VAL out.
REQ-018 When rst and en=0 are sampled on the same edge, reset SHALL win.

Configuration
REQ-019 Macro D_FF_CE_EN: when defined, port en exists, and an edge with rst=0, en=0 holds every stage unchanged; en=1 behaves as REQ-009.
REQ-020 When D_FF_CE_EN is undefined, port en SHALL be absent and the block SHALL behave as if en were permanently 1.

Verification
REQ-021 The bench SHALL use a 10-unit clk period with the first rising edge at t=5, rst=1 until t=7, then d=0 until t=21, 1 until t=63, 0 until t=84, then 1. Required response with defaults: Q=0 after edges 5 and 15; Q=1 after edges 25..55; Q=0 after edge 65; Q=0 after edge 75; Q=1 after edge 85.
REQ-022 The bench SHALL toggle d between rising edges (for example, pulse d high from t=11 to t=14). Required response: Q does not change.
REQ-023 The bench SHALL assert rst=1 for one edge while Q=1, with RST_VAL=0. Required response: Q=0 after that edge, and Q follows d from the next edge.
REQ-024 The bench SHALL use STAGES=3, WIDTH=8, and drive d=8'hA5 for one edge after reset. Required response: Q=8'hA5 exactly three edges later, and 8'h00 before that.
REQ-025 With D_FF_CE_EN defined, the bench SHALL set en=0, change d, and run 2 edges. Required response: Q holds. It SHALL then apply rst=1 with en=0. Required response: Q=RST_VAL.
REQ-026 The bench SHALL use RST_VAL=8'hFF, WIDTH=8, and reset. Required response: Q=8'hFF after the reset edge.
